// File: rtl/alu8_sequencer.sv
// alu8_sequencer
// Drives an external 4-bit combinational ALU to perform 8-bit AND/OR/ADD/SUB
// as two nibble passes (low nibble first, carry chained into the high pass).
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   in_valid/in_ready      command handshake; in_op (00 AND, 01 OR, 10 ADD,
//                          11 SUB), in_a, in_b operands
//   out_valid/out_ready    result handshake; out_res, out_cout, out_zero
//   alu_a/alu_b/alu_cin/alu_op  registered drive to the external ALU
//   alu_res/alu_cout       combinational ALU response
module alu8_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_op,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_res,
    output logic       out_cout,
    output logic       out_zero,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    output logic [1:0] alu_op,
    input  logic [3:0] alu_res,
    input  logic       alu_cout
);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [3:0] res_lo_q, res_lo_d;
    logic [7:0] out_res_q, out_res_d;
    logic       out_cout_q, out_cout_d;
    logic       out_zero_q, out_zero_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic       alu_cin_q, alu_cin_d;
    logic [1:0] alu_op_q, alu_op_d;

    logic       in_sub;
    logic       q_sub;
    logic       q_arith;
    logic [7:0] full_res;

    assign in_sub   = (in_op == OP_SUB);
    assign q_sub    = (op_q == OP_SUB);
    assign q_arith  = op_q[1];            // ADD or SUB
    assign full_res = {alu_res, res_lo_q};

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        res_lo_d   = res_lo_q;
        out_res_d  = out_res_q;
        out_cout_d = out_cout_q;
        out_zero_d = out_zero_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_cin_d  = alu_cin_q;
        alu_op_d   = alu_op_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d      = in_op;
                    a_d       = in_a;
                    b_d       = in_b;
                    // SUB runs as A + ~B + 1 on the ALU's ADD function
                    alu_a_d   = in_a[3:0];
                    alu_b_d   = in_sub ? ~in_b[3:0] : in_b[3:0];
                    alu_cin_d = in_sub;
                    alu_op_d  = in_sub ? OP_ADD : in_op;
                    state_d   = S_LO;
                end
            end
            S_LO: begin
                res_lo_d  = alu_res;
                alu_a_d   = a_q[7:4];
                alu_b_d   = q_sub ? ~b_q[7:4] : b_q[7:4];
                // the low-pass carry goes straight into the high-pass cin
                alu_cin_d = q_arith & alu_cout;
                state_d   = S_HI;
            end
            S_HI: begin
                out_res_d  = full_res;
                out_cout_d = q_arith & alu_cout;
                out_zero_d = (full_res == 8'h00);
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 2'b00;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            res_lo_q   <= 4'h0;
            out_res_q  <= 8'h00;
            out_cout_q <= 1'b0;
            out_zero_q <= 1'b0;
            alu_a_q    <= 4'h0;
            alu_b_q    <= 4'h0;
            alu_cin_q  <= 1'b0;
            alu_op_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_lo_q   <= res_lo_d;
            out_res_q  <= out_res_d;
            out_cout_q <= out_cout_d;
            out_zero_q <= out_zero_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_cin_q  <= alu_cin_d;
            alu_op_q   <= alu_op_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_res   = out_res_q;
    assign out_cout  = out_cout_q;
    assign out_zero  = out_zero_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;
    assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_alu8_sequencer.sv
// Testbench for alu8_sequencer: external 4-bit ALU model, a transaction-level
// reference that tracks where the command stands and what must be on the
// outputs, a per-cycle compare process, and directed vectors with literal
// expectations.
module tb_alu8_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_op = 2'b00;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_res;
    logic       out_cout;
    logic       out_zero;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_cin;
    logic [1:0] alu_op;
    logic [3:0] alu_res;
    logic       alu_cout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu8_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_cout(out_cout), .out_zero(out_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_res(alu_res), .alu_cout(alu_cout)
    );

    // External combinational 4-bit ALU
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum = 5'd0;
        case (alu_op)
            2'b00: alu_sum = {1'b0, alu_a & alu_b};
            2'b01: alu_sum = {1'b0, alu_a | alu_b};
            2'b10: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
            default: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        endcase
    end
    assign alu_res  = alu_sum[3:0];
    assign alu_cout = alu_sum[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // 8-bit reference result: {carry, result}
    function automatic logic [8:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   ref_op = {1'b0, a & b};
            2'b01:   ref_op = {1'b0, a | b};
            2'b10:   ref_op = {1'b0, a} + {1'b0, b};
            default: ref_op = {1'b0, a} + {1'b0, ~b} + 9'd1;
        endcase
    endfunction

    // Reference: phase 0 idle, 1 low pass, 2 high pass, 3 result held
    int         m_ph = 0;
    bit         m_fresh = 1'b0;  // reset seen, no command accepted since
    bit         armed = 1'b0;
    logic [1:0] m_op = 2'b00;
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_fresh = 1'b1; armed = 1'b1;
        end else begin
            case (m_ph)
                0: if (in_valid) begin
                       m_op = in_op; m_a = in_a; m_b = in_b;
                       m_ph = 1; m_fresh = 1'b0;
                   end
                1: m_ph = 2;
                2: m_ph = 3;
                default: if (out_ready) m_ph = 0;
            endcase
        end
    end

    // Per-cycle compare against the reference
    always @(negedge clk) begin
        logic       sub;
        logic [7:0] bb;
        logic [4:0] lo5;
        logic [8:0] r9;
        if (armed) begin
            sub = (m_op == 2'b11);
            bb  = sub ? ~m_b : m_b;
            lo5 = {1'b0, m_a[3:0]} + {1'b0, bb[3:0]} + {4'd0, sub};
            r9  = ref_op(m_op, m_a, m_b);
            chk("in_ready", in_ready, m_ph == 0);
            chk("out_valid", out_valid, m_ph == 3);
            if (m_fresh) begin
                chk("rst_alu", {alu_a, alu_b, alu_cin, alu_op}, 0);
                chk("rst_out", {out_res, out_cout, out_zero}, 0);
            end
            if (m_ph == 1 || m_ph == 2)
                chk("alu_op", alu_op, sub ? 2'b10 : m_op);
            if (m_ph == 1) begin
                chk("lo_a", alu_a, m_a[3:0]);
                chk("lo_b", alu_b, bb[3:0]);
                chk("lo_cin", alu_cin, sub);
            end
            if (m_ph == 2) begin
                chk("hi_a", alu_a, m_a[7:4]);
                chk("hi_b", alu_b, bb[7:4]);
                chk("hi_cin", alu_cin, m_op[1] & lo5[4]);
            end
            if (m_ph == 3) begin
                chk("res", out_res, r9[7:0]);
                chk("cout", out_cout, m_op[1] & r9[8]);
                chk("zero", out_zero, r9[7:0] == 8'h00);
            end
        end
    end

    // Issue one command, capture what the ALU saw in each pass, wait for the
    // result, then consume it.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [3:0] lo_a, output logic [3:0] lo_b,
                          output logic lo_cin, output logic [1:0] lo_op,
                          output logic [3:0] hi_a, output logic [3:0] hi_b,
                          output logic hi_cin, output int lat,
                          output logic [7:0] r, output logic c, output logic z);
        @(negedge clk);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_a = ~a; in_b = ~b; in_op = ~op;  // must not matter
        @(negedge clk);
        lo_a = alu_a; lo_b = alu_b; lo_cin = alu_cin; lo_op = alu_op;
        @(negedge clk);
        hi_a = alu_a; hi_b = alu_b; hi_cin = alu_cin;
        lat = 3;
        @(negedge clk);
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        r = out_res; c = out_cout; z = out_zero;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    logic [3:0] la, lb, ha, hb;
    logic       lc, hc, c, z;
    logic [1:0] lo;
    logic [7:0] r;
    int         lat;

    initial begin
        // Reset with in_valid held high: nothing may be accepted
        rst = 1'b1; in_valid = 1'b1; in_op = 2'b10; in_a = 8'h12; in_b = 8'h34;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_alu", {alu_a, alu_b, alu_cin, alu_op}, 0);

        // ADD with carry chain
        do_cmd(2'b10, 8'h3C, 8'h0F, la, lb, lc, lo, ha, hb, hc, lat, r, c, z);
        chk("add_lo_drive", {la, lb, lc}, {4'hC, 4'hF, 1'b0});
        chk("add_hi_drive", {ha, hb, hc}, {4'h3, 4'h0, 1'b1});
        chk("add_res", {r, c, z}, {8'h4B, 1'b0, 1'b0});
        chk("add_latency", lat, 3);

        // ADD overflow
        do_cmd(2'b10, 8'hFF, 8'h01, la, lb, lc, lo, ha, hb, hc, lat, r, c, z);
        chk("ovf_res", {r, c, z}, {8'h00, 1'b1, 1'b1});

        // SUB, no borrow
        do_cmd(2'b11, 8'h10, 8'h01, la, lb, lc, lo, ha, hb, hc, lat, r, c, z);
        chk("sub1_res", {r, c}, {8'h0F, 1'b1});

        // SUB, borrow
        do_cmd(2'b11, 8'h01, 8'h02, la, lb, lc, lo, ha, hb, hc, lat, r, c, z);
        chk("sub2_res", {r, c, z}, {8'hFF, 1'b0, 1'b0});
        chk("sub2_lo_drive", {lo, lb, lc}, {2'b10, 4'hD, 1'b1});

        // Logic ops
        do_cmd(2'b00, 8'hA5, 8'h0F, la, lb, lc, lo, ha, hb, hc, lat, r, c, z);
        chk("and_res", {r, c, hc}, {8'h05, 1'b0, 1'b0});
        do_cmd(2'b01, 8'hA0, 8'h05, la, lb, lc, lo, ha, hb, hc, lat, r, c, z);
        chk("or_res", {r, c, hc}, {8'hA5, 1'b0, 1'b0});

        // Backpressure: result held 5 cycles while in_valid pulses
        @(negedge clk);
        in_op = 2'b10; in_a = 8'h12; in_b = 8'h34; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", lat, 3);
        in_a = 8'h77; in_b = 8'h11; in_op = 2'b11;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            @(negedge clk);
            chk("bp_hold", {out_valid, in_ready, out_res, out_cout}, {1'b1, 1'b0, 8'h46, 1'b0});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_release", {in_ready, out_valid}, {1'b1, 1'b0});

        // Reset during the high pass aborts the command
        in_op = 2'b11; in_a = 8'h55; in_b = 8'hAA; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);   // low pass
        @(negedge clk);   // high pass
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_idle", {in_ready, out_valid, out_res}, {1'b1, 1'b0, 8'h00});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/alu8_sequencer.md
# alu8_sequencer

Multi-cycle controller that drives the team's external 4-bit combinational ALU (operands a/b, carry-in cin, 2-bit op, result res, carry-out cout). It executes 8-bit AND/OR/ADD/SUB operations as two nibble passes: the low nibble first, then the high nibble with the carry chained between passes. Commands arrive and results leave over valid/ready handshakes. The block sits between the datapath command source and the ALU.

## Interface
Parameters: none; the width is fixed at 8 bits, split into two 4-bit passes.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command valid
- in_ready  out  1  block can accept a command
- in_op  in  2  00 AND, 01 OR, 10 ADD, 11 SUB
- in_a  in  8  operand A
- in_b  in  8  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_res  out  8  result
- out_cout  out  1  carry out of bit 7 (ADD/SUB); 0 for AND/OR
- out_zero  out  1  out_res == 0
- alu_a  out  4  nibble driven to ALU a
- alu_b  out  4  nibble driven to ALU b
- alu_cin  out  1  ALU carry-in
- alu_op  out  2  ALU op select
- alu_res  in  4  ALU result (combinational from the alu_* outputs)
- alu_cout  in  1  ALU carry-out

## Operation
- FSM states: IDLE, LO, HI, DONE. Reset enters IDLE.
- Reset values: in_ready=1; out_valid=0; out_res=0; out_cout=0; out_zero=0; all alu_* outputs=0.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_op, in_a and in_b, then go to LO.
  - On the same edge, load alu_a=in_a[3:0] and alu_b=in_b[3:0], inverted for SUB.
  - alu_cin=1 for SUB, else 0.
  - alu_op=in_op for AND/OR/ADD; alu_op=10 for SUB.
- LO:
  - in_ready=0.
  - At the edge, capture alu_res into res[3:0] and alu_cout into an internal carry.
  - Load alu_a=a[7:4] and alu_b=b[7:4] (inverted for SUB).
  - alu_cin = captured carry for ADD/SUB, 0 for AND/OR.
  - Go to HI.
- HI:
  - At the edge, capture alu_res into res[7:4].
  - out_cout = alu_cout for ADD/SUB, 0 for AND/OR.
  - out_zero computed from the full 8-bit result.
  - Set out_valid=1 and go to DONE.
- DONE:
  - out_valid=1; out_res, out_cout and out_zero hold stable.
  - On out_ready: out_valid=0 and go to IDLE; in_ready returns to 1 the next cycle.
- SUB semantics: A + ~B + 1. out_cout=1 means no borrow; out_cout=0 means borrow.
- Only one command is in flight at a time. in_valid outside IDLE is ignored, and commands are never queued.
- Operands are latched at accept. Changing in_a, in_b or in_op after accept has no effect.
- The ALU is treated as purely combinational. alu_res and alu_cout are sampled at the end of the same cycle the alu_* outputs are stable.

## Timing
- Cycle 0: accept edge (in_valid & in_ready).
- Cycle 1: LO.
- Cycle 2: HI.
- Cycle 3: out_valid=1 at the earliest.
- Latency from accept to out_valid: 3 clocks.
- Back-to-back throughput: one command per 4 clocks when out_ready is tied high.
- out_valid may stay high indefinitely under backpressure. No output changes while it is held.
- rst asserted in any state, including mid-LO/HI or while DONE is stalled:
  - next edge returns to IDLE with all outputs at reset values;
  - any partial result is discarded.
- rst has priority over simultaneous in_valid or out_ready.

## Test plan
- Reset: hold rst for 2 cycles with in_valid=1. Required: in_ready=1, out_valid=0, all alu_* =0, and no command accepted.
- ADD with carry chain: in_a=0x3C, in_b=0x0F, op=10.
  - LO drives alu_a=C, alu_b=F, cin=0.
  - HI drives alu_a=3, alu_b=0, cin=1.
  - Result: out_res=0x4B, out_cout=0, out_zero=0, exactly 3 clocks after accept.
- ADD overflow: 0xFF + 0x01. Required: out_res=0x00, out_cout=1, out_zero=1.
- SUB:
  - 0x10 − 0x01: out_res=0x0F, out_cout=1.
  - 0x01 − 0x02: out_res=0xFF, out_cout=0. LO must drive alu_op=10, alu_b=~2=D, cin=1.
- Logic ops: 0xA5 AND 0x0F gives 0x05; 0xA0 OR 0x05 gives 0xA5. out_cout=0 in both cases, and HI alu_cin=0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles with in_valid pulsing. Required: the result is stable, in_ready=0, and no new accept occurs.
  - Then assert rst during a following HI state. Required: IDLE on the next cycle, out_valid never asserted for the aborted command.
